// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges MEM/WB pipeline writes with buffered long-latency results onto
// the single register-file write port. Define WB_BYPASS_EN to add output-stage forward ports.
module wb_arbiter #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned MAX_WAIT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pipe_valid,
   input  logic [4:0]        pipe_reg,
   input  logic [DATA_W-1:0] pipe_data,
   output logic              pipe_stall,
   input  logic              lu_valid,
   output logic              lu_ready,
   input  logic [4:0]        lu_reg,
   input  logic [DATA_W-1:0] lu_data,
   output logic              regwrite,
   output logic [4:0]        writeReg,
   output logic [DATA_W-1:0] writeData,
`ifdef WB_BYPASS_EN
   output logic              fwd1_valid,
   output logic [DATA_W-1:0] fwd1_data,
   output logic              fwd2_valid,
   output logic [DATA_W-1:0] fwd2_data,
`endif
   input  logic [4:0]        chk_reg1,
   input  logic [4:0]        chk_reg2,
   output logic              busy1,
   output logic              busy2
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned WW = $clog2(MAX_WAIT + 1);

   logic [4:0]        fifo_reg  [DEPTH];
   logic [DATA_W-1:0] fifo_data [DEPTH];
   logic [PW-1:0]     rd_ptr, wr_ptr;
   logic [CW-1:0]     count;
   logic [WW-1:0]     wait_cnt;

   logic empty, full, pipe_win, grant_pipe, pop, push;
   logic hit1, hit2;

   always_comb begin
      empty      = (count == '0);
      full       = (count == CW'(DEPTH));
      lu_ready   = rst | ~full;
      pipe_stall = ~rst & ~empty & (wait_cnt == WW'(MAX_WAIT));
      pipe_win   = pipe_valid & (pipe_reg != 5'd0);
      // Head drains when forced by starvation or whenever the pipeline has no real write.
      pop        = ~empty & (pipe_stall | ~pipe_win);
      grant_pipe = pipe_win & ~pipe_stall;
      // Writes to r0 complete the handshake but are dropped.
      push       = lu_valid & ~full & (lu_reg != 5'd0);
   end

   always_comb begin
      hit1 = 1'b0;
      hit2 = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (CW'(i) < count) begin
            if (fifo_reg[rd_ptr + PW'(i)] == chk_reg1) hit1 = 1'b1;
            if (fifo_reg[rd_ptr + PW'(i)] == chk_reg2) hit2 = 1'b1;
         end
      end
      if (push && lu_reg == chk_reg1) hit1 = 1'b1;
      if (push && lu_reg == chk_reg2) hit2 = 1'b1;
`ifdef WB_BYPASS_EN
      fwd1_valid = regwrite & (writeReg == chk_reg1) & (chk_reg1 != 5'd0);
      fwd2_valid = regwrite & (writeReg == chk_reg2) & (chk_reg2 != 5'd0);
      fwd1_data  = writeData;
      fwd2_data  = writeData;
`else
      if (regwrite && writeReg == chk_reg1) hit1 = 1'b1;
      if (regwrite && writeReg == chk_reg2) hit2 = 1'b1;
`endif
      busy1 = (chk_reg1 != 5'd0) & hit1;
      busy2 = (chk_reg2 != 5'd0) & hit2;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_reg[wr_ptr]  <= lu_reg;
         fifo_data[wr_ptr] <= lu_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         wait_cnt  <= '0;
         regwrite  <= 1'b0;
         writeReg  <= 5'd0;
         writeData <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count    <= count + CW'(push) - CW'(pop);
         wait_cnt <= (~empty & ~pop) ? wait_cnt + WW'(1) : '0;
         regwrite <= grant_pipe | pop;
         if (grant_pipe) begin
            writeReg  <= pipe_reg;
            writeData <= pipe_data;
         end else if (pop) begin
            writeReg  <= fifo_reg[rd_ptr];
            writeData <= fifo_data[rd_ptr];
         end
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_wb_arbiter;

   localparam int DATA_W   = 32;
   localparam int DEPTH    = 4;
   localparam int MAX_WAIT = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst = 1'b1;
   logic              pipe_valid = 1'b0;
   logic [4:0]        pipe_reg = '0;
   logic [DATA_W-1:0] pipe_data = '0;
   logic              pipe_stall;
   logic              lu_valid = 1'b0;
   logic              lu_ready;
   logic [4:0]        lu_reg = '0;
   logic [DATA_W-1:0] lu_data = '0;
   logic              regwrite;
   logic [4:0]        writeReg;
   logic [DATA_W-1:0] writeData;
   logic [4:0]        chk_reg1 = '0;
   logic [4:0]        chk_reg2 = '0;
   logic              busy1, busy2;
`ifdef WB_BYPASS_EN
   logic              fwd1_valid, fwd2_valid;
   logic [DATA_W-1:0] fwd1_data, fwd2_data;
`endif

   wb_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst(rst),
      .pipe_valid(pipe_valid), .pipe_reg(pipe_reg), .pipe_data(pipe_data),
      .pipe_stall(pipe_stall),
      .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_reg(lu_reg), .lu_data(lu_data),
      .regwrite(regwrite), .writeReg(writeReg), .writeData(writeData),
`ifdef WB_BYPASS_EN
      .fwd1_valid(fwd1_valid), .fwd1_data(fwd1_data),
      .fwd2_valid(fwd2_valid), .fwd2_data(fwd2_data),
`endif
      .chk_reg1(chk_reg1), .chk_reg2(chk_reg2), .busy1(busy1), .busy2(busy2)
   );

   int tests = 0;
   int fails = 0;

   // Model state: pending long-latency results in arrival order, {reg, data}.
   logic [DATA_W+4:0] q[$];
   int                denied = 0;
   logic              exp_rw = 1'b0;
   logic [4:0]        exp_wr = '0;
   logic [DATA_W-1:0] exp_wd = '0;
   bit                model_on = 1'b0;
   bit                last_stall = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit exp_busy(input logic [4:0] r, input bit can_push);
      if (r == 5'd0) return 1'b0;
      foreach (q[i]) if (q[i][DATA_W+4:DATA_W] == r) return 1'b1;
      if (lu_valid && can_push && lu_reg != 5'd0 && lu_reg == r) return 1'b1;
`ifndef WB_BYPASS_EN
      if (exp_rw && exp_wr == r) return 1'b1;
`endif
      return 1'b0;
   endfunction

   // Compare at the falling edge, then advance the model across the coming rising edge.
   task automatic cycle();
      int n;
      bit e_ready, e_stall, pw, can_push;
      logic [DATA_W+4:0] h;
      @(negedge clk);
      n        = q.size();
      can_push = (n < DEPTH);
      e_ready  = rst || can_push;
      e_stall  = !rst && n > 0 && denied == MAX_WAIT;
      if (model_on) begin
         check("m_lu_ready", 32'(lu_ready), 32'(e_ready));
         check("m_pipe_stall", 32'(pipe_stall), 32'(e_stall));
         check("m_regwrite", 32'(regwrite), 32'(exp_rw));
         check("m_writeReg", 32'(writeReg), 32'(exp_wr));
         check("m_writeData", 32'(writeData), 32'(exp_wd));
         if (!rst) begin
            check("m_busy1", 32'(busy1), 32'(exp_busy(chk_reg1, can_push)));
            check("m_busy2", 32'(busy2), 32'(exp_busy(chk_reg2, can_push)));
         end
`ifdef WB_BYPASS_EN
         check("m_fwd1_valid", 32'(fwd1_valid),
               32'(exp_rw && exp_wr == chk_reg1 && chk_reg1 != 0));
         check("m_fwd2_valid", 32'(fwd2_valid),
               32'(exp_rw && exp_wr == chk_reg2 && chk_reg2 != 0));
         if (exp_rw) check("m_fwd1_data", fwd1_data, exp_wd);
`endif
      end
      last_stall = e_stall;
      if (rst) begin
         q.delete();
         denied   = 0;
         exp_rw   = 1'b0;
         exp_wr   = '0;
         exp_wd   = '0;
         model_on = 1'b1;
      end else begin
         pw = pipe_valid && pipe_reg != 5'd0;
         if (n > 0 && (e_stall || !pw)) begin
            h      = q.pop_front();
            exp_rw = 1'b1;
            exp_wr = h[DATA_W+4:DATA_W];
            exp_wd = h[DATA_W-1:0];
            denied = 0;
         end else begin
            exp_rw = pw;
            if (pw) begin
               exp_wr = pipe_reg;
               exp_wd = pipe_data;
            end
            denied = (n > 0) ? denied + 1 : 0;
         end
         if (lu_valid && can_push && lu_reg != 5'd0) q.push_back({lu_reg, lu_data});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      pipe_valid = 1'b0;
      lu_valid   = 1'b0;
      for (int i = 0; i < 20 && q.size() != 0; i++) cycle();
      check("drain_empty", 32'(q.size()), 32'd0);
      cycle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset then idle
      cycle();
      cycle();
      check("rst_regwrite", 32'(regwrite), 32'd0);
      check("rst_writeReg", 32'(writeReg), 32'd0);
      check("rst_writeData", writeData, 32'd0);
      check("rst_lu_ready", 32'(lu_ready), 32'd1);
      check("rst_pipe_stall", 32'(pipe_stall), 32'd0);
      rst = 1'b0;

      // Pipeline-only write, then a write to r0
      pipe_valid = 1'b1; pipe_reg = 5'd5; pipe_data = 32'h1234;
      cycle();
      check("pipe_regwrite", 32'(regwrite), 32'd1);
      check("pipe_writeReg", 32'(writeReg), 32'd5);
      check("pipe_writeData", writeData, 32'h1234);
      pipe_reg = 5'd0; pipe_data = 32'hdead;
      cycle();
      check("r0_regwrite", 32'(regwrite), 32'd0);
      check("r0_hold_reg", 32'(writeReg), 32'd5);

      // Long-latency result lands two cycles after its handshake
      pipe_valid = 1'b0;
      lu_valid = 1'b1; lu_reg = 5'd9; lu_data = 32'hAAAA; chk_reg1 = 5'd9;
      cycle();
      lu_valid = 1'b0;
      #1;
      check("lu9_busy_fifo", 32'(busy1), 32'd1);
      check("lu9_not_yet", 32'(regwrite), 32'd0);
      cycle();
      check("lu9_regwrite", 32'(regwrite), 32'd1);
      check("lu9_writeReg", 32'(writeReg), 32'd9);
      check("lu9_writeData", writeData, 32'hAAAA);
      drain();

      // Fill the FIFO while the pipeline keeps the port
      pipe_valid = 1'b1; pipe_reg = 5'd3; pipe_data = 32'h3333;
      for (int i = 0; i < 4; i++) begin
         lu_valid = 1'b1; lu_reg = 5'(20 + i); lu_data = 32'(i);
         #1;
         check("fill_ready", 32'(lu_ready), 32'd1);
         cycle();
      end
      lu_reg = 5'd24;
      #1;
      check("full_ready", 32'(lu_ready), 32'd0);
      cycle();
      check("full_still", 32'(lu_ready), 32'd0);
      drain();

      // Starvation: head forced out on the 9th non-empty cycle
      pipe_valid = 1'b1; pipe_reg = 5'd4; pipe_data = 32'h4444;
      lu_valid = 1'b1; lu_reg = 5'd7; lu_data = 32'h7777;
      cycle();
      lu_valid = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         #1;
         check("starve_stall", 32'(pipe_stall), 32'(k == 9));
         cycle();
      end
      check("starve_w7_rw", 32'(regwrite), 32'd1);
      check("starve_w7_reg", 32'(writeReg), 32'd7);
      check("starve_w7_data", writeData, 32'h7777);
      cycle();
      check("starve_w4_reg", 32'(writeReg), 32'd4);
      check("starve_w4_data", writeData, 32'h4444);
      drain();

      // Busy query
      pipe_valid = 1'b1; pipe_reg = 5'd5; pipe_data = 32'h55;
      lu_valid = 1'b1; lu_reg = 5'd12; lu_data = 32'h5555;
      chk_reg1 = 5'd12; chk_reg2 = 5'd0;
      #1;
      check("busy_push", 32'(busy1), 32'd1);
      cycle();
      lu_valid = 1'b0;
      #1;
      check("busy_fifo", 32'(busy1), 32'd1);
      check("busy_r0", 32'(busy2), 32'd0);
      pipe_valid = 1'b0;
      cycle();
      check("busy_out_reg", 32'(writeReg), 32'd12);
`ifdef WB_BYPASS_EN
      check("busy_out_bypass", 32'(busy1), 32'd0);
      check("fwd_valid", 32'(fwd1_valid), 32'd1);
      check("fwd_data", fwd1_data, 32'h5555);
`else
      check("busy_out_stage", 32'(busy1), 32'd1);
`endif
      cycle();
      check("busy_retired", 32'(busy1), 32'd0);
      drain();

      // Reset mid-operation discards buffered results
      pipe_valid = 1'b1; pipe_reg = 5'd6; pipe_data = 32'h66;
      for (int i = 0; i < 3; i++) begin
         lu_valid = 1'b1; lu_reg = 5'(13 + i); lu_data = 32'(100 + i);
         cycle();
      end
      lu_valid = 1'b0; pipe_valid = 1'b0; rst = 1'b1; chk_reg1 = 5'd13;
      cycle();
      rst = 1'b0;
      #1;
      check("mid_rst_ready", 32'(lu_ready), 32'd1);
      check("mid_rst_busy", 32'(busy1), 32'd0);
      for (int i = 0; i < 6; i++) begin
         cycle();
         check("mid_rst_nowrite", 32'(regwrite), 32'd0);
      end

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 199) == 0);
         if (!last_stall) begin
            pipe_valid = ($urandom_range(0, 9) < 7);
            pipe_reg   = 5'($urandom_range(0, 7));
            pipe_data  = $urandom;
         end
         lu_valid = $urandom_range(0, 1) == 1;
         lu_reg   = 5'($urandom_range(0, 7));
         lu_data  = $urandom;
         chk_reg1 = 5'($urandom_range(0, 7));
         chk_reg2 = 5'($urandom_range(0, 7));
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
